eq_gain_scheduler: RTL and testbench
====================================

Name: eq_gain_scheduler

Overview:
- Applies a programmable gain to each band output of the FIR filter bank and sums the results into one equalized 24-bit sample.
- Uses one shared signed multiplier, time-multiplexed across all bands; a small FSM schedules it, one band per clock.
- Sits directly after the filter bank. Gains come from a simple register-write port driven by the control/UI logic.

Parameters:
- NUM_BANDS, 10, number of band inputs (lowpass, 8 band-pass, highpass); 2..16
- DATA_W, 24, band sample and output width, signed
- GAIN_W, 12, gain word width, signed two's complement
- GAIN_FRAC, 10, fractional bits of gain (Q2.10 at default: range -2.0..+1.999, 1.0 = 0x400)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_valid  in  1  one-cycle strobe: band_in holds a new sample set
- band_in  in  NUM_BANDS*DATA_W  packed signed band samples; band i at bits [i*DATA_W +: DATA_W], band 0 = lowpass
- gain_wr_en  in  1  gain register write strobe
- gain_wr_addr  in  4  band index to write
- gain_wr_data  in  GAIN_W  signed gain value
- overrun_clr  in  1  clears the overrun flag
- audio_out  out  DATA_W  signed equalized sample, held until next result
- out_valid  out  1  one-cycle pulse: audio_out updated
- busy  out  1  high while a frame is in progress (state != IDLE)
- overrun  out  1  sticky: sample_valid arrived while busy

Behaviour:
- Reset (rst=1 at clk edge), from any state, including mid-frame:
  - state=IDLE, audio_out=0, out_valid=0, overrun=0, accumulator=0, index=0.
  - All shadow and active gains = 1.0 (1<<GAIN_FRAC).
  - A frame in progress is aborted; no out_valid is produced for it.
- Gain registers:
  - Writes go to the shadow set. gain_wr_en with gain_wr_addr >= NUM_BANDS is ignored.
  - Active gains are copied from shadow only when a frame is accepted. Gains used inside a frame never change mid-frame.
  - A write in the same cycle as an accepted sample_valid is included in the copy (write-through).
- FSM states: IDLE, MAC, OUT. A sample_valid is accepted at edge k with state=IDLE.
  - Edge k, IDLE->MAC: capture band_in into an internal sample register, copy shadow->active, acc=0, idx=0.
  - Edges k+1..k+NUM_BANDS, MAC: acc += sample[idx]*gain[idx] (full-precision signed product), idx++. After the idx=NUM_BANDS-1 update, go to OUT.
  - Edge k+NUM_BANDS+1, OUT->IDLE: audio_out <= sat(round(acc)); out_valid=1 for exactly the following cycle.
- Timing:
  - Latency from accepting edge to out_valid = NUM_BANDS+1 clocks (11 at default).
  - Minimum sample spacing = NUM_BANDS+2 clocks. The next accept is possible at edge k+NUM_BANDS+2.
- busy is combinational (state != IDLE). It is 0 in the cycle out_valid is high.
- Overrun:
  - sample_valid while state != IDLE is dropped (no capture, frame unaffected) and sets overrun=1.
  - overrun_clr clears it. If overrun_clr and a new overrun occur in the same cycle, set wins.
- Arithmetic:
  - Accumulator width = DATA_W+GAIN_W+ceil(log2(NUM_BANDS)) (40 at default); it never wraps.
  - Round half up: r = (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, arithmetic shift.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (0x800000..0x7FFFFF at default).
- audio_out holds its value between out_valid pulses.

Test Plan:
- After reset: all band_in=1000, gains default, one sample_valid -> out_valid exactly 11 clocks later; audio_out=10000; busy high for 11 cycles; overrun=0.
- Rounding: gains 0 except band0=0x200 (0.5). band0=3 -> audio_out=2; band0=-3 -> audio_out=-1.
- Saturation: all bands 0x7FFFFF at gain 1.0 -> 0x7FFFFF; all bands 0x800000 -> 0x800000; no wrap.
- Gain write mid-frame: write band3=0 at frame cycle 4 with bands=100 -> current output 1000, next frame 900. Write in the same cycle as sample_valid -> that frame outputs 900.
- Overrun: second sample_valid 5 clocks after the first -> first result unchanged, only one out_valid, overrun=1 until overrun_clr. Sample_valid exactly 12 clocks after the first -> accepted, no overrun.
- Reset mid-frame: assert rst at frame cycle 6 -> no out_valid; audio_out=0; gains back to 0x400; next frame behaves as after reset.

Source files
------------

// File: rtl/eq_gain_scheduler.sv
// Per-band gain and summing stage behind the FIR filter bank. One signed multiplier is shared
// across the bands, one band per clock, and the rounded, saturated sum is emitted per frame.
module eq_gain_scheduler #(
  parameter int unsigned NUM_BANDS = 10,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned GAIN_W    = 12,
  parameter int unsigned GAIN_FRAC = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
  input  logic                          gain_wr_en,
  input  logic [3:0]                    gain_wr_addr,
  input  logic [GAIN_W-1:0]             gain_wr_data,
  input  logic                          overrun_clr,
  output logic [DATA_W-1:0]             audio_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned IDX_W  = $clog2(NUM_BANDS);
  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned ACC_W  = DATA_W + GAIN_W + $clog2(NUM_BANDS);

  localparam logic signed [GAIN_W-1:0] GainUnity = GAIN_W'(1 << GAIN_FRAC);
  localparam logic signed [ACC_W:0]    RoundHalf = (ACC_W + 1)'(1 << (GAIN_FRAC - 1));

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   sample_q [NUM_BANDS];
  logic signed [GAIN_W-1:0]   shadow_q [NUM_BANDS];
  logic signed [GAIN_W-1:0]   shadow_d [NUM_BANDS];
  logic signed [GAIN_W-1:0]   active_q [NUM_BANDS];
  logic signed [ACC_W-1:0]    acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic [DATA_W-1:0]          audio_q;
  logic                       out_valid_q;
  logic                       overrun_q;

  logic                       mac_last;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W:0]      acc_ext;
  logic signed [ACC_W:0]      rnd;
  logic [DATA_W-1:0]          sat;

  // Shadow next-state doubles as the copy source, so a write on the accept cycle is included.
  always_comb begin
    for (int i = 0; i < NUM_BANDS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (gain_wr_en && (gain_wr_addr == 4'(i))) shadow_d[i] = gain_wr_data;
    end
  end

  always_comb begin
    mac_last = (idx_q == IDX_W'(NUM_BANDS - 1));
    state_d  = state_q;
    unique case (state_q)
      StIdle:  if (sample_valid) state_d = StMac;
      StMac:   if (mac_last) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prod     = sample_q[idx_q] * active_q[idx_q];
    prod_ext = ACC_W'(prod);
    acc_ext  = (ACC_W + 1)'(acc_q);
    rnd      = (acc_ext + RoundHalf) >>> GAIN_FRAC;
    // In range when every bit above the output sign bit matches it.
    if ((&rnd[ACC_W:DATA_W-1]) || !(|rnd[ACC_W:DATA_W-1])) begin
      sat = rnd[DATA_W-1:0];
    end else if (rnd[ACC_W]) begin
      sat = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat = {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      idx_q       <= '0;
      audio_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        sample_q[i] <= '0;
        shadow_q[i] <= GainUnity;
        active_q[i] <= GainUnity;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= shadow_d[i];

      if (sample_valid && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (sample_valid) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              sample_q[i] <= band_in[i*DATA_W +: DATA_W];
              active_q[i] <= shadow_d[i];
            end
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          idx_q <= idx_q + 1'b1;
        end
        StOut: begin
          audio_q     <= sat;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign audio_out = audio_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler at default parameters; expected values are hand-computed.
module tb_eq_gain_scheduler;

  localparam int NB = 10;
  localparam int DW = 24;
  localparam int GW = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_valid;
  logic [NB*DW-1:0] band_in;
  logic             gain_wr_en;
  logic [3:0]       gain_wr_addr;
  logic [GW-1:0]    gain_wr_data;
  logic             overrun_clr;
  logic [DW-1:0]    audio_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  eq_gain_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .band_in      (band_in),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_addr (gain_wr_addr),
    .gain_wr_data (gain_wr_data),
    .overrun_clr  (overrun_clr),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_band(input int b, input int v);
    band_in[b*DW +: DW] = v[DW-1:0];
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NB; i++) set_band(i, v);
  endtask

  task automatic write_gain(input int a, input int d);
    gain_wr_en   = 1'b1;
    gain_wr_addr = a[3:0];
    gain_wr_data = d[GW-1:0];
    tick();
    gain_wr_en   = 1'b0;
  endtask

  task automatic set_gains_all(input int d);
    for (int i = 0; i < NB; i++) write_gain(i, d);
  endtask

  task automatic start();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check("out_valid_seen", longint'(out_valid), 1);
  endtask

  task automatic frame(input string tag, input longint exp);
    int lat, bcnt;
    start();
    wait_out(lat, bcnt);
    check({tag, "_lat"}, lat, 11);
    check(tag, $signed(audio_out), exp);
    tick();
  endtask

  initial begin
    int lat, bcnt, npulse;
    longint val;

    rst = 1'b1; sample_valid = 1'b0; gain_wr_en = 1'b0; gain_wr_addr = '0;
    gain_wr_data = '0; overrun_clr = 1'b0; band_in = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_audio", $signed(audio_out), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);

    // Unity gains: 10 bands of 1000 sum to 10000.
    set_all(1000);
    start();
    wait_out(lat, bcnt);
    check("first_lat", lat, 11);
    check("first_busy_cycles", bcnt, 11);
    check("first_audio", $signed(audio_out), 10000);
    check("busy_at_out_valid", longint'(busy), 0);
    check("first_overrun", longint'(overrun), 0);
    tick();
    check("pulse_width", longint'(out_valid), 0);
    check("audio_hold", $signed(audio_out), 10000);

    // Round half up: 3*0.5 -> 2, -3*0.5 -> -1.
    set_gains_all(0);
    write_gain(0, 'h200);
    set_all(0);
    set_band(0, 3);
    frame("round_pos", 2);
    set_band(0, -3);
    frame("round_neg", -1);

    set_gains_all('h400);
    set_all('h7FFFFF);
    frame("sat_pos", 8388607);
    set_all('h800000);
    frame("sat_neg", -8388608);

    // Mid-frame write lands only in the next frame.
    set_all(100);
    start();
    repeat (3) tick();
    write_gain(3, 0);
    wait_out(lat, bcnt);
    check("midwrite_cur", $signed(audio_out), 1000);
    tick();
    frame("midwrite_next", 900);
    write_gain(3, 'h400);
    write_gain(10, 0);
    write_gain(15, 0);
    frame("bad_addr_ignored", 1000);

    gain_wr_en = 1'b1; gain_wr_addr = 4'd3; gain_wr_data = '0;
    start();
    gain_wr_en = 1'b0;
    wait_out(lat, bcnt);
    check("writethru_lat", lat, 11);
    check("writethru", $signed(audio_out), 900);
    tick();
    write_gain(3, 'h400);

    // Sample 5 clocks into a frame is dropped.
    set_all(100);
    start();
    repeat (4) tick();
    set_all(500);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_set", longint'(overrun), 1);
    npulse = 0;
    val = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) begin
        npulse++;
        val = $signed(audio_out);
      end
      tick();
    end
    check("overrun_pulses", npulse, 1);
    check("overrun_result", val, 1000);
    check("overrun_sticky", longint'(overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", longint'(overrun), 0);

    // Back-to-back at the minimum spacing of 12 clocks.
    set_all(100);
    start();
    wait_out(lat, bcnt);
    check("spacing_first", $signed(audio_out), 1000);
    set_all(200);
    start();
    check("spacing_no_overrun", longint'(overrun), 0);
    wait_out(lat, bcnt);
    check("spacing_lat", lat, 11);
    check("spacing_second", $signed(audio_out), 2000);
    tick();

    start();
    tick();
    sample_valid = 1'b1;
    overrun_clr  = 1'b1;
    tick();
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
    check("overrun_set_wins", longint'(overrun), 1);
    wait_out(lat, bcnt);
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;

    // Reset at frame cycle 6 aborts the frame and restores unity gains.
    set_gains_all('h200);
    set_all(100);
    start();
    tick();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_overrun", longint'(overrun), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_audio", $signed(audio_out), 0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) npulse++;
      tick();
    end
    check("midrst_no_pulse", npulse, 0);
    set_all(1000);
    frame("post_reset", 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
